// File: rtl/kyber_io_pkg.sv
// Shared constants and types for the Kyber word-serial host bridge.
package kyber_io_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_READ = 2'd2;

    localparam logic [2:0] SEL_COIN = 3'd0;
    localparam logic [2:0] SEL_M    = 3'd1;
    localparam logic [2:0] SEL_PK   = 3'd2;
    localparam logic [2:0] SEL_SK   = 3'd3;
    localparam logic [2:0] SEL_C    = 3'd4;

    localparam int unsigned N_COIN = 8;
    localparam int unsigned N_M    = 8;
    localparam int unsigned N_PK   = 200;
    localparam int unsigned N_SK   = 192;
    localparam int unsigned N_C    = 192;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWait,
        StRead
    } state_e;

    // Index of the final word of the selected buffer.
    function automatic logic [CNT_W-1:0] last_word(input logic [2:0] sel);
        case (sel)
            SEL_COIN: return CNT_W'(N_COIN - 1);
            SEL_M:    return CNT_W'(N_M - 1);
            SEL_PK:   return CNT_W'(N_PK - 1);
            SEL_SK:   return CNT_W'(N_SK - 1);
            default:  return CNT_W'(N_C - 1);
        endcase
    endfunction

endpackage

// File: rtl/io_word_mux.sv
// Selects 32-bit word[idx] from a wide bus; out-of-range indices yield zero.
module io_word_mux #(
    parameter int unsigned BusW = 256,
    parameter int unsigned IdxW = 8
) (
    input  logic [BusW-1:0] bus,
    input  logic [IdxW-1:0] idx,
    output logic [31:0]     word
);

    localparam int unsigned NWords = BusW / 32;

    always_comb begin
        word = '0;
        for (int unsigned i = 0; i < NWords; i++) begin
            if (idx == IdxW'(i)) begin
                word = bus[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/kyber_io_bridge.sv
// Word-serial bridge: loads wide Kyber operands from a 32-bit stream, runs the
// core, and streams its wide results back out.
module kyber_io_bridge
    import kyber_io_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [2:0]     cmd_sel,
    input  logic [1:0]     cmd_mode,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    output logic           core_start,
    output logic [1:0]     core_mode,
    input  logic           core_finish,
    output logic [255:0]   core_random_coin,
    output logic [255:0]   core_m_in,
    output logic [6399:0]  core_pk_in,
    output logic [6143:0]  core_sk_in,
    output logic [6143:0]  core_c_in,
    input  logic [255:0]   core_m_out,
    input  logic [6399:0]  core_pk_out,
    input  logic [6143:0]  core_sk_out,
    input  logic [6143:0]  core_c_out,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [1:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             cmd_ok;
    logic             wr_en;
    logic [CNT_W-1:0] last;

    logic [255:0]  coin_q;
    logic [255:0]  m_q;
    logic [6399:0] pk_q;
    logic [6143:0] sk_q;
    logic [6143:0] c_q;

    logic [W-1:0] word_m, word_pk, word_sk, word_c;

    assign last = last_word(sel_q);

    always_comb begin
        cmd_ok = 1'b0;
        case (cmd_op)
            OP_LOAD: cmd_ok = (cmd_sel <= SEL_C);
            OP_RUN:  cmd_ok = 1'b1;
            OP_READ: cmd_ok = (cmd_sel != SEL_COIN) && (cmd_sel <= SEL_C);
            default: cmd_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        core_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!cmd_ok) begin
                        err_d = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_LOAD: begin
                                state_d = StLoad;
                                sel_d   = cmd_sel;
                                cnt_d   = '0;
                            end
                            OP_RUN: begin
                                state_d = StStart;
                                mode_d  = cmd_mode;
                            end
                            default: begin
                                state_d = StRead;
                                sel_d   = cmd_sel;
                                cnt_d   = '0;
                            end
                        endcase
                    end
                end
            end
            StLoad: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                core_start = 1'b1;
                state_d    = StWait;
            end
            StWait: begin
                if (core_finish) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StRead: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    if (cnt_q == last) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sel_q   <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Unwritten words keep their previous contents; only reset clears buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin_q <= '0;
            m_q    <= '0;
            pk_q   <= '0;
            sk_q   <= '0;
            c_q    <= '0;
        end else if (wr_en) begin
            case (sel_q)
                SEL_COIN: coin_q[W*cnt_q +: W] <= s_data;
                SEL_M:    m_q[W*cnt_q +: W]    <= s_data;
                SEL_PK:   pk_q[W*cnt_q +: W]   <= s_data;
                SEL_SK:   sk_q[W*cnt_q +: W]   <= s_data;
                default:  c_q[W*cnt_q +: W]    <= s_data;
            endcase
        end
    end

    io_word_mux #(.BusW(256),  .IdxW(CNT_W)) u_mux_m  (.bus(core_m_out),  .idx(cnt_q), .word(word_m));
    io_word_mux #(.BusW(6400), .IdxW(CNT_W)) u_mux_pk (.bus(core_pk_out), .idx(cnt_q), .word(word_pk));
    io_word_mux #(.BusW(6144), .IdxW(CNT_W)) u_mux_sk (.bus(core_sk_out), .idx(cnt_q), .word(word_sk));
    io_word_mux #(.BusW(6144), .IdxW(CNT_W)) u_mux_c  (.bus(core_c_out),  .idx(cnt_q), .word(word_c));

    always_comb begin
        case (sel_q)
            SEL_M:   m_data = word_m;
            SEL_PK:  m_data = word_pk;
            SEL_SK:  m_data = word_sk;
            SEL_C:   m_data = word_c;
            default: m_data = '0;
        endcase
    end

    assign m_last           = (state_q == StRead) && (cnt_q == last);
    assign core_mode        = mode_q;
    assign busy             = (state_q != StIdle);
    assign done             = done_q;
    assign err              = err_q;
    assign core_random_coin = coin_q;
    assign core_m_in        = m_q;
    assign core_pk_in       = pk_q;
    assign core_sk_in       = sk_q;
    assign core_c_in        = c_q;

endmodule

// File: tb/tb_kyber_io_bridge.sv
// Directed self-checking bench for kyber_io_bridge.
module tb_kyber_io_bridge;
    import kyber_io_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [2:0]    cmd_sel;
    logic [1:0]    cmd_mode;
    logic          s_valid, s_ready;
    logic [31:0]   s_data;
    logic          m_valid, m_ready, m_last;
    logic [31:0]   m_data;
    logic          core_start, core_finish;
    logic [1:0]    core_mode;
    logic [255:0]  core_random_coin, core_m_in, core_m_out;
    logic [6399:0] core_pk_in, core_pk_out;
    logic [6143:0] core_sk_in, core_sk_out, core_c_in, core_c_out;
    logic          busy, done, err;

    always #5 clk = ~clk;

    kyber_io_bridge dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
        .cmd_mode(cmd_mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_start(core_start), .core_mode(core_mode), .core_finish(core_finish),
        .core_random_coin(core_random_coin), .core_m_in(core_m_in), .core_pk_in(core_pk_in),
        .core_sk_in(core_sk_in), .core_c_in(core_c_in),
        .core_m_out(core_m_out), .core_pk_out(core_pk_out), .core_sk_out(core_sk_out),
        .core_c_out(core_c_out),
        .busy(busy), .done(done), .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0, done_cnt = 0, err_cnt = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (core_start === 1'b1) start_cnt++;
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    // Called #1 after a rising edge with the bridge idle; returns #1 after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [2:0] sel, input logic [1:0] mode);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_mode  = mode;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    logic [255:0] exp_m;
    logic [31:0]  held_d;
    logic         held_l, stalled;
    int           rd_idx, rd_cyc, start_before, err_before, done_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0; cmd_mode = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b0; core_finish = 1'b0;
        core_m_out = '0; core_sk_out = '0; core_c_out = '0;
        for (int i = 0; i < 200; i++) core_pk_out[32*i +: 32] = 32'(i);

        // Reset values, sampled mid-cycle while reset is held.
        #12;
        check_val("rst_cmd_ready", cmd_ready, 1'b1);
        check_val("rst_s_ready", s_ready, 1'b0);
        check_val("rst_m_valid", m_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_pk_in", |core_pk_in, 1'b0);
        check_val("rst_pulses", {core_start, done, err}, 3'b000);
        check_val("rst_mode", core_mode, 2'd0);
        #5 rst = 1'b1;
        @(posedge clk); #1;

        // LOAD M with stream gaps.
        send_cmd(OP_LOAD, SEL_M, 2'd0);
        check_val("load_s_ready", s_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            exp_m[32*i +: 32] = 32'h1111_1111 * 32'(i + 1);
            if (i == 3 || i == 6) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = 32'h1111_1111 * 32'(i + 1);
            if (i == 7) check_val("load_busy_last", cmd_ready, 1'b0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check_val("load_cmd_ready", cmd_ready, 1'b1);
        check_val("load_m_in", core_m_in, exp_m);
        check_val("load_m_in_hex", core_m_in,
                  256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
        check_val("load_coin_untouched", core_random_coin, 256'd0);

        // RUN mode 2 with finish 40 cycles after start.
        start_before = start_cnt;
        send_cmd(OP_RUN, 3'd0, 2'd2);
        @(negedge clk);
        check_val("run_start", core_start, 1'b1);
        check_val("run_busy", busy, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 39; i++) begin
            @(posedge clk); #1;
        end
        core_finish = 1'b1;
        @(negedge clk);
        check_val("run_no_early_done", done, 1'b0);
        check_val("run_mode_held", core_mode, 2'd2);
        check_val("run_wait_busy", busy, 1'b1);
        check_val("run_start_once", start_cnt - start_before, 1);
        @(posedge clk); #1;
        core_finish = 1'b0;
        @(negedge clk);
        check_val("run_done", done, 1'b1);
        check_val("run_idle", busy, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("run_done_pulse", done, 1'b0);
        done_before = done_cnt;
        @(posedge clk); #1;
        core_finish = 1'b1;
        @(posedge clk); #1;
        core_finish = 1'b0;
        @(negedge clk);
        check_val("idle_finish_no_done", done, 1'b0);
        check_val("idle_finish_cnt", done_cnt - done_before, 0);
        @(posedge clk); #1;

        // READ PK with random stalls.
        send_cmd(OP_READ, SEL_PK, 2'd0);
        check_val("read_valid_first", m_valid, 1'b1);
        rd_idx = 0; rd_cyc = 0; stalled = 1'b0;
        while (rd_idx < 200 && rd_cyc < 2000) begin
            m_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled) begin
                check_val("read_stall_data", m_data, held_d);
                check_val("read_stall_last", m_last, held_l);
            end
            if (m_valid && m_ready) begin
                check_val("read_data", m_data, 32'(rd_idx));
                check_val("read_last", m_last, rd_idx == 199);
                rd_idx++;
                stalled = 1'b0;
            end else begin
                check_val("read_valid", m_valid, 1'b1);
                stalled = m_valid;
                held_d  = m_data;
                held_l  = m_last;
            end
            @(posedge clk); #1;
            rd_cyc++;
        end
        m_ready = 1'b0;
        check_val("read_count", rd_idx, 200);
        @(negedge clk);
        check_val("read_end_valid", m_valid, 1'b0);
        check_val("read_end_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Illegal commands, with stray stream data that must be ignored.
        err_before = err_cnt;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        send_cmd(OP_LOAD, 3'd6, 2'd0);
        @(negedge clk);
        check_val("err_sel", err, 1'b1);
        check_val("err_sel_idle", busy, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("err_pulse", err, 1'b0);
        @(posedge clk); #1;
        send_cmd(2'd3, SEL_M, 2'd0);
        @(negedge clk);
        check_val("err_op", err, 1'b1);
        @(posedge clk); #1;
        send_cmd(OP_READ, SEL_COIN, 2'd0);
        @(negedge clk);
        check_val("err_read_coin", err, 1'b1);
        check_val("err_no_read", m_valid, 1'b0);
        check_val("err_idle", cmd_ready, 1'b1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(negedge clk);
        check_val("err_count", err_cnt - err_before, 3);
        check_val("err_m_unchanged", core_m_in, exp_m);
        check_val("err_coin_unchanged", core_random_coin, 256'd0);
        @(posedge clk); #1;

        // Reset in the middle of a PK load.
        err_before  = err_cnt;
        done_before = done_cnt;
        send_cmd(OP_LOAD, SEL_PK, 2'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_data = 32'hC000_0000 + 32'(i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_cmd_ready", cmd_ready, 1'b1);
        check_val("abort_s_ready", s_ready, 1'b0);
        check_val("abort_pk_clear", |core_pk_in, 1'b0);
        check_val("abort_m_clear", core_m_in, 256'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_no_pulses", (err_cnt - err_before) + (done_cnt - done_before), 0);

        // Full PK load afterwards: 200 words back to back.
        send_cmd(OP_LOAD, SEL_PK, 2'd0);
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            s_data = 32'hA500_0000 + 32'(i);
            if (i == 199) check_val("pk_busy_last", cmd_ready, 1'b0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check_val("pk_cmd_ready", cmd_ready, 1'b1);
        for (int i = 0; i < 200; i++) begin
            check_val("pk_word", core_pk_in[32*i +: 32], 32'hA500_0000 + 32'(i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
